// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared types and load encodings for the writeback stage
package wb_stage_pkg;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_e;
  typedef enum logic {IDLE, WAIT_LOAD} wb_state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-side, D-cache and register-file signals of the writeback stage
interface wb_stage_if #(parameter int XLEN = 32, parameter int REG_AW = 5, parameter int CNT_W = 64);
  logic              flush;
  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_wr;
  logic [1:0]        mem_wb_sel;
  logic [2:0]        mem_funct3;
  logic [XLEN-1:0]   mem_alu_res;
  logic [XLEN-1:0]   mem_pc4;
  logic [XLEN-1:0]   mem_csr_rd;
  logic              dc_rvalid;
  logic [XLEN-1:0]   dc_rdata;
  logic              W_en;
  logic [REG_AW-1:0] addres_D;
  logic [XLEN-1:0]   data_in;
  logic              wb_retire;
  logic [CNT_W-1:0]  instret;
  modport master (
    output flush, mem_valid, mem_rd, mem_reg_wr, mem_wb_sel, mem_funct3, mem_alu_res, mem_pc4,
           mem_csr_rd, dc_rvalid, dc_rdata,
    input  mem_ready, W_en, addres_D, data_in, wb_retire, instret
  );
  modport slave (
    input  flush, mem_valid, mem_rd, mem_reg_wr, mem_wb_sel, mem_funct3, mem_alu_res, mem_pc4,
           mem_csr_rd, dc_rvalid, dc_rdata,
    output mem_ready, W_en, addres_D, data_in, wb_retire, instret
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// wb_stage_load_align: extracts and extends the addressed byte/half from a D-cache word
module wb_stage_load_align
  import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = word[{addr, 3'b000} +: 8];
    assign h = addr[1] ? word[31:16] : word[15:0];
    assign result = funct3 == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
                    funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
                    funct3 == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
                    funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, h} : word;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, load-miss wait FSM, result select and instret counter
module wb_stage
  import wb_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input logic       clk,
    input logic       rst,
    wb_stage_if.slave bus
);
    wb_state_e         state, state_n;
    logic [REG_AW-1:0] rd_q, rd_c;
    logic              wr_q, wr_c;
    logic [2:0]        f3_q, f3_c;
    logic [1:0]        addr_q, addr_c;
    logic              cap, is_mem, commit;
    logic [XLEN-1:0]   ld, res;
    wb_sel_e           sel;
    assign sel    = wb_sel_e'(bus.mem_wb_sel);
    assign is_mem = sel == WB_MEM;
    assign cap    = bus.mem_valid && bus.mem_ready && !bus.flush;
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    always_comb begin
        state_n = state == IDLE ? ((cap && is_mem && !bus.dc_rvalid) ? WAIT_LOAD : IDLE)
                                : ((bus.flush || bus.dc_rvalid) ? IDLE : WAIT_LOAD);
    end
    always_comb begin
        bus.mem_ready = state == IDLE;
        commit = state == IDLE ? cap && (!is_mem || bus.dc_rvalid) : !bus.flush && bus.dc_rvalid;
    end
    // A waiting load commits from the held entry; everything else commits straight from MEM.
    always_comb begin
        rd_c   = state == IDLE ? bus.mem_rd : rd_q;
        wr_c   = state == IDLE ? bus.mem_reg_wr : wr_q;
        f3_c   = state == IDLE ? bus.mem_funct3 : f3_q;
        addr_c = state == IDLE ? bus.mem_alu_res[1:0] : addr_q;
        res    = (state == WAIT_LOAD || is_mem) ? ld :
                 sel == WB_PC4 ? bus.mem_pc4 :
                 sel == WB_CSR ? bus.mem_csr_rd : bus.mem_alu_res;
    end
    wb_stage_load_align #(.XLEN(XLEN)) u_align (
        .funct3(f3_c),
        .addr  (addr_c),
        .word  (bus.dc_rdata),
        .result(ld)
    );
    always_ff @(posedge clk) begin
        if (cap) begin
            rd_q   <= bus.mem_rd;
            wr_q   <= bus.mem_reg_wr;
            f3_q   <= bus.mem_funct3;
            addr_q <= bus.mem_alu_res[1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.W_en      <= 1'b0;
            bus.addres_D  <= '0;
            bus.data_in   <= '0;
            bus.wb_retire <= 1'b0;
            bus.instret   <= '0;
        end else begin
            bus.W_en      <= commit && wr_c && rd_c != '0;
            bus.addres_D  <= commit ? rd_c : '0;
            bus.data_in   <= commit ? res : '0;
            bus.wb_retire <= commit;
            if (commit) bus.instret <= bus.instret + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random checks of wb_stage against a transaction-level model
module tb_wb_stage;
    logic clk = 0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    always #5 clk = ~clk;
    wb_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(64)) b1 ();
    wb_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(3))  b2 ();
    wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(64)) dut  (.clk(clk), .rst(rst), .bus(b1));
    wb_stage #(.XLEN(32), .REG_AW(5), .CNT_W(3))  dut2 (.clk(clk), .rst(rst), .bus(b2));
    assign b2.flush       = b1.flush;
    assign b2.mem_valid   = b1.mem_valid;
    assign b2.mem_rd      = b1.mem_rd;
    assign b2.mem_reg_wr  = b1.mem_reg_wr;
    assign b2.mem_wb_sel  = b1.mem_wb_sel;
    assign b2.mem_funct3  = b1.mem_funct3;
    assign b2.mem_alu_res = b1.mem_alu_res;
    assign b2.mem_pc4     = b1.mem_pc4;
    assign b2.mem_csr_rd  = b1.mem_csr_rd;
    assign b2.dc_rvalid   = b1.dc_rvalid;
    assign b2.dc_rdata    = b1.dc_rdata;

    bit          pend = 0;
    logic [4:0]  p_rd;
    logic        p_wr;
    logic [2:0]  p_f3;
    logic [1:0]  p_a;
    logic [63:0] cnt = 0;
    logic        e_wen, e_ret, e_ready;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [63:0] e_cnt;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ldval(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] byt, half;
        byt  = w >> (8 * a);
        half = a[1] ? w >> 16 : w;
        case (f3)
            3'd0:    return 32'($signed(byt[7:0]));
            3'd4:    return 32'(byt[7:0]);
            3'd1:    return 32'($signed(half[15:0]));
            3'd5:    return 32'(half[15:0]);
            default: return w;
        endcase
    endfunction

    // Predicts the outputs visible after the coming edge from the inputs currently driven.
    task automatic model();
        bit c = 0;
        logic [4:0] rd = 0;
        logic wr = 0;
        logic [31:0] v = 0;
        if (rst) begin
            pend = 0;
            cnt  = 0;
        end else if (pend) begin
            if (!b1.flush && b1.dc_rvalid) begin
                c = 1; rd = p_rd; wr = p_wr; v = ldval(p_f3, p_a, b1.dc_rdata);
            end
            if (b1.flush || b1.dc_rvalid) pend = 0;
        end else if (b1.mem_valid && !b1.flush) begin
            rd = b1.mem_rd; wr = b1.mem_reg_wr;
            if (b1.mem_wb_sel == 2'd1) begin
                if (b1.dc_rvalid) begin
                    c = 1; v = ldval(b1.mem_funct3, b1.mem_alu_res[1:0], b1.dc_rdata);
                end else begin
                    pend = 1; p_rd = rd; p_wr = wr; p_f3 = b1.mem_funct3; p_a = b1.mem_alu_res[1:0];
                end
            end else begin
                c = 1;
                v = b1.mem_wb_sel == 2'd0 ? b1.mem_alu_res : b1.mem_wb_sel == 2'd2 ? b1.mem_pc4 : b1.mem_csr_rd;
            end
        end
        if (c) cnt++;
        e_ret   = c;
        e_wen   = c && wr && rd != 0;
        e_rd    = c ? rd : 0;
        e_data  = c ? v : 0;
        e_cnt   = cnt;
        e_ready = !pend;
    endtask

    task automatic tick();
        model();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input bit v, input bit fl, input logic [4:0] rd, input bit wr, input logic [1:0] sel,
                          input logic [2:0] f3, input logic [31:0] alu, input bit rv, input logic [31:0] rdata);
        b1.mem_valid = v; b1.flush = fl; b1.mem_rd = rd; b1.mem_reg_wr = wr; b1.mem_wb_sel = sel;
        b1.mem_funct3 = f3; b1.mem_alu_res = alu; b1.dc_rvalid = rv; b1.dc_rdata = rdata;
        b1.mem_pc4 = 32'h0; b1.mem_csr_rd = 32'h0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("W_en", b1.W_en, e_wen);
            chk("wb_retire", b1.wb_retire, e_ret);
            chk("instret", b1.instret, e_cnt);
            chk("mem_ready", b1.mem_ready, e_ready);
            if (e_wen || !e_ret) begin
                chk("addres_D", b1.addres_D, e_rd);
                chk("data_in", b1.data_in, e_data);
            end
            chk("instret_w3", b2.instret, e_cnt[2:0]);
            chk("W_en_w3", b2.W_en, e_wen);
        end
    end

    initial begin
        rst = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_wen", b1.W_en, 0);
        chk("rst_retire", b1.wb_retire, 0);
        chk("rst_instret", b1.instret, 0);
        chk("rst_ready", b1.mem_ready, 1);
        rst = 0;
        set_in(1, 0, 5, 1, 2'd0, 0, 32'h1234, 0, 0);
        tick();
        chk("alu_wen", b1.W_en, 1);
        chk("alu_rd", b1.addres_D, 5);
        chk("alu_data", b1.data_in, 32'h1234);
        chk("alu_instret", b1.instret, 1);
        set_in(1, 0, 7, 1, 2'd1, 3'd0, 32'h1003, 1, 32'h80FF_FF11);
        tick();
        chk("lb_data", b1.data_in, 32'hFFFF_FF80);
        set_in(1, 0, 7, 1, 2'd1, 3'd4, 32'h1003, 1, 32'h80FF_FF11);
        tick();
        chk("lbu_data", b1.data_in, 32'h0000_0080);
        chk("lbu_instret", b1.instret, 3);
        set_in(1, 0, 9, 1, 2'd1, 3'd1, 32'h2002, 0, 0);
        tick();
        chk("miss_ready0", b1.mem_ready, 0);
        chk("miss_wen0", b1.W_en, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("miss_ready1", b1.mem_ready, 0);
        tick();
        chk("miss_ready2", b1.mem_ready, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'h9ABC_0000);
        tick();
        chk("lh_wen", b1.W_en, 1);
        chk("lh_rd", b1.addres_D, 9);
        chk("lh_data", b1.data_in, 32'hFFFF_9ABC);
        chk("lh_ready", b1.mem_ready, 1);
        set_in(1, 0, 0, 1, 2'd0, 0, 32'h55, 0, 0);
        tick();
        chk("rd0_wen", b1.W_en, 0);
        chk("rd0_retire", b1.wb_retire, 1);
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 0, 5'(i), 1, 2'd0, 0, 32'(i * 16), 0, 0);
            tick();
            chk("b2b_retire", b1.wb_retire, 1);
            chk("b2b_data", b1.data_in, 64'(i * 16));
        end
        chk("b2b_instret", b1.instret, 9);
        set_in(1, 0, 3, 1, 2'd1, 3'd2, 32'h40, 0, 0);
        tick();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        tick();
        chk("flush_wen", b1.W_en, 0);
        chk("flush_retire", b1.wb_retire, 0);
        chk("flush_instret", b1.instret, 9);
        chk("flush_ready", b1.mem_ready, 1);
        set_in(1, 0, 3, 1, 2'd1, 3'd2, 32'h40, 0, 0);
        tick();
        rst = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 0;
        chk("rstw_wen", b1.W_en, 0);
        chk("rstw_instret", b1.instret, 0);
        chk("rstw_ready", b1.mem_ready, 1);
        for (int i = 0; i < 8; i++) begin
            set_in(1, 0, 1, 1, 2'd0, 0, 32'h1, 0, 0);
            tick();
        end
        chk("wrap_w3", b2.instret, 0);
        chk("wrap_w64", b1.instret, 8);
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 63) == 0;
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 5'($urandom), 1'($urandom),
                   2'($urandom), 3'($urandom), $urandom, $urandom_range(0, 2) == 0, $urandom);
            b1.mem_pc4 = $urandom;
            b1.mem_csr_rd = $urandom;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
